// File: rtl/fifo_uart_pkg.sv
// rtl/fifo_uart_pkg.sv - shared state encoding and frame constants for the FIFO-fed UART transmitter
package fifo_uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Total rclk cycles from the first start-bit cycle to the last stop-bit cycle.
  function automatic int frame_cycles(input int clks_per_bit, input int parity_en, input int stop_bits);
    return (1 + DATA_W + parity_en + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// rtl/tx_bit_timer.sv - baud counter producing a one-cycle pulse on the last cycle of each serial bit
module tx_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last  = (r_cnt == LAST);
  assign bit_end = run & ~clear & w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops bytes from the read-side FIFO and serialises them as UART frames
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              enable,
  input  logic              rempty,
  input  logic [DATA_W-1:0] rdata,
  output logic              rinc,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam logic HAS_PARITY = (PARITY_EN != 0);
  localparam logic ODD_PARITY = (PARITY_ODD != 0);
  localparam logic LAST_STOP  = (STOP_BITS == 2);

  tx_state_t         r_state;
  tx_state_t         w_state_next;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_next;
  logic              r_parity;
  logic              w_parity_next;
  logic [2:0]        r_bit_cnt;
  logic [2:0]        w_bit_cnt_next;
  logic              r_stop_cnt;
  logic              w_stop_cnt_next;
  logic              r_tx;
  logic              w_tx_next;
  logic              w_pop;
  logic              w_done;
  logic              w_bit_end;
  logic              w_timer_clear;
  logic              w_timer_run;

  assign w_timer_clear = (r_state == ST_IDLE);
  assign w_timer_run   = (r_state != ST_IDLE);

  tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (rclk),
    .rst_n  (rrst_n),
    .clear  (w_timer_clear),
    .run    (w_timer_run),
    .bit_end(w_bit_end)
  );

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_shift_next    = r_shift;
    w_parity_next   = r_parity;
    w_bit_cnt_next  = r_bit_cnt;
    w_stop_cnt_next = r_stop_cnt;
    w_pop           = 1'b0;
    w_done          = 1'b0;
    w_tx_next       = 1'b1;

    case (r_state)
      ST_IDLE: begin
        // Held off during reset so the pop never precedes the first live edge.
        if (rrst_n && enable && !rempty) begin
          w_pop           = 1'b1;
          w_shift_next    = rdata;
          w_parity_next   = (^rdata) ^ ODD_PARITY;
          w_bit_cnt_next  = 3'd0;
          w_stop_cnt_next = 1'b0;
          w_state_next    = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_shift_next   = {1'b0, r_shift[DATA_W-1:1]};
          w_bit_cnt_next = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_state_next = HAS_PARITY ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          if (r_stop_cnt == LAST_STOP) begin
            w_done       = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_stop_cnt_next = r_stop_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // The line register follows the state being entered, so tx changes on the same edge as the state.
    case (w_state_next)
      ST_START:  w_tx_next = 1'b0;
      ST_DATA:   w_tx_next = w_shift_next[0];
      ST_PARITY: w_tx_next = w_parity_next;
      default:   w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_bit_cnt  <= 3'd0;
      r_stop_cnt <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_shift    <= w_shift_next;
      r_parity   <= w_parity_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_stop_cnt <= w_stop_cnt_next;
      r_tx       <= w_tx_next;
    end
  end

  assign rinc    = w_pop;
  assign tx      = r_tx;
  assign busy    = (r_state != ST_IDLE);
  assign tx_done = w_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - scoreboard bench for fifo_uart_tx over three parity/stop-bit configurations
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int C   = 4;
  localparam int NCH = 3;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
  } exp_t;

  logic       clk = 1'b0;
  logic       rrst_n;
  logic       enable;
  logic       rempty  [NCH];
  logic [7:0] rdata   [NCH];
  logic       rinc    [NCH];
  logic       tx      [NCH];
  logic       busy    [NCH];
  logic       tx_done [NCH];

  logic [7:0] fifo_q [NCH][$];
  exp_t       exp_q  [NCH][$];
  logic       pop_pend [NCH];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   in_frame [NCH];
  int   cyc      [NCH];
  int   idle_bad [NCH];
  int   pops     [NCH];
  int   tx_edges [NCH];
  int   lost     [NCH];
  logic frame_bad [NCH];
  logic done_bad  [NCH];
  logic prev_tx   [NCH];
  logic bits      [NCH][12];

  always #5 clk = ~clk;

  // ch0: no parity, 1 stop; ch1: even parity, 2 stops; ch2: odd parity, 1 stop
  for (genvar g = 0; g < NCH; g++) begin : g_dut
    fifo_uart_tx #(
      .CLKS_PER_BIT(C),
      .PARITY_EN   ((g == 0) ? 0 : 1),
      .PARITY_ODD  ((g == 2) ? 1 : 0),
      .STOP_BITS   ((g == 1) ? 2 : 1)
    ) u_dut (
      .rclk   (clk),
      .rrst_n (rrst_n),
      .enable (enable),
      .rempty (rempty[g]),
      .rdata  (rdata[g]),
      .rinc   (rinc[g]),
      .tx     (tx[g]),
      .busy   (busy[g]),
      .tx_done(tx_done[g])
    );
  end

  function automatic int nbits(int k);
    return (k == 0) ? 10 : ((k == 1) ? 12 : 11);
  endfunction

  function automatic void check(string name, int k, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s ch%0d: got 0x%0h, expected 0x%0h", name, k, act, exp);
    end
  endfunction

  function automatic void refresh(int k);
    rempty[k] = (fifo_q[k].size() == 0);
    rdata[k]  = (fifo_q[k].size() != 0) ? fifo_q[k][0] : 8'h00;
  endfunction

  task automatic push(int k, logic [7:0] d, logic p);
    exp_t e;
    e.data = d;
    e.par  = p;
    fifo_q[k].push_back(d);
    exp_q[k].push_back(e);
    refresh(k);
  endtask

  function automatic void finish_frame(int k);
    logic [7:0] d;
    logic       ok;
    exp_t       e;
    for (int i = 0; i < 8; i++) d[i] = bits[k][1 + i];
    ok = !frame_bad[k] && (bits[k][0] === 1'b0);
    for (int i = ((k == 0) ? 9 : 10); i < nbits(k); i++) begin
      if (bits[k][i] !== 1'b1) ok = 1'b0;
    end
    check("framing", k, ok, 1);
    check("tx_done_timing", k, !done_bad[k], 1);
    if (exp_q[k].size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_frame ch%0d: got 0x%0h, expected no frame", k, d);
    end else begin
      e = exp_q[k].pop_front();
      check("byte", k, d, e.data);
      if (k != 0) check("parity", k, bits[k][9], e.par);
    end
  endfunction

  // FIFO read-block model: the pop seen mid-cycle retires the head just after the capturing edge.
  always @(negedge clk) begin
    for (int k = 0; k < NCH; k++) pop_pend[k] = rrst_n && (rinc[k] === 1'b1);
  end

  always @(posedge clk) begin
    #2;
    for (int k = 0; k < NCH; k++) begin
      if (pop_pend[k]) begin
        if (fifo_q[k].size() != 0) void'(fifo_q[k].pop_front());
        refresh(k);
      end
    end
  end

  // Monitor: decodes each line cycle by cycle and retires scoreboard entries at frame end.
  always @(negedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      int bi;
      int off;
      if (!rrst_n) begin
        if (in_frame[k] != 0) begin
          in_frame[k] = 0;
          lost[k]++;
          if (exp_q[k].size() != 0) void'(exp_q[k].pop_front());
        end
      end else begin
        if (tx[k] !== prev_tx[k]) tx_edges[k]++;
        prev_tx[k] = tx[k];
        if (in_frame[k] != 0) begin
          cyc[k]++;
          bi  = (cyc[k] - 1) / C;
          off = (cyc[k] - 1) % C;
          if (off == 0) bits[k][bi] = tx[k];
          else if (tx[k] !== bits[k][bi]) frame_bad[k] = 1'b1;
          if (busy[k] !== 1'b1 || rinc[k] !== 1'b0) frame_bad[k] = 1'b1;
          if (tx_done[k] !== (cyc[k] == nbits(k) * C)) done_bad[k] = 1'b1;
          if (cyc[k] == nbits(k) * C) begin
            finish_frame(k);
            in_frame[k] = 0;
          end
        end else if (rinc[k] === 1'b1) begin
          pops[k]++;
          check("rinc_nonempty", k, rempty[k], 0);
          in_frame[k]  = 1;
          cyc[k]       = 0;
          frame_bad[k] = (tx[k] !== 1'b1) || (busy[k] !== 1'b0);
          done_bad[k]  = 1'b0;
        end else if (tx[k] !== 1'b1 || busy[k] !== 1'b0 || tx_done[k] !== 1'b0) begin
          idle_bad[k]++;
        end
      end
    end
  end

  task automatic wait_drained(int k);
    int t = 0;
    while ((exp_q[k].size() != 0 || busy[k] !== 1'b0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("drain_in_time", k, (t < 2000), 1);
  endtask

  task automatic wait_pop(int k);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (rinc[k] !== 1'b1 && t < 200);
    check("pop_seen", k, rinc[k], 1);
  endtask

  initial begin
    int t;
    int gap;
    int p;
    int e;
    rrst_n = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      in_frame[k] = 0; cyc[k] = 0; idle_bad[k] = 0; pops[k] = 0;
      tx_edges[k] = 0; lost[k] = 0; frame_bad[k] = 1'b0; done_bad[k] = 1'b0;
      prev_tx[k] = 1'b1; pop_pend[k] = 1'b0;
      refresh(k);
    end
    push(0, 8'hA5, 1'b0);
    push(1, 8'hA5, 1'b0);
    push(1, 8'h07, 1'b1);
    push(2, 8'hA5, 1'b1);
    push(2, 8'h07, 1'b0);

    // Reset held with data waiting: line idle, no pop
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tx", 0, tx[0], 1);
    check("reset_rinc", 0, rinc[0], 0);
    check("reset_busy", 0, busy[0], 0);
    @(posedge clk);
    #1 rrst_n = 1'b1;
    #1 check("release_rinc", 0, rinc[0], 1);
    @(posedge clk);
    #1;
    check("rinc_one_cycle", 0, rinc[0], 0);
    check("start_latency", 0, tx[0], 0);
    wait_drained(0);

    // Back-to-back frames with a single idle cycle between them
    @(posedge clk);
    #1;
    p = pops[0];
    push(0, 8'h3C, 1'b0);
    push(0, 8'hC3, 1'b0);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (tx_done[0] !== 1'b1 && t < 200);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (tx[0] !== 1'b0 && gap < 10);
    check("b2b_gap", 0, gap, 2);
    wait_drained(0);
    check("b2b_pops", 0, pops[0] - p, 2);
    wait_drained(1);
    wait_drained(2);

    // enable dropped during DATA: frame finishes, nothing more is popped
    @(posedge clk);
    #1;
    push(0, 8'h11, 1'b0);
    push(0, 8'h22, 1'b0);
    push(0, 8'h33, 1'b0);
    wait_pop(0);
    repeat (12) @(posedge clk);
    #1 enable = 1'b0;
    p = pops[0];
    t = 0;
    while (busy[0] !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    e = tx_edges[0];
    repeat (40) @(negedge clk);
    check("hold_no_pop", 0, pops[0] - p, 0);
    check("hold_tx_quiet", 0, tx_edges[0] - e, 0);
    check("hold_fifo_kept", 0, fifo_q[0].size(), 2);
    @(posedge clk);
    #1 enable = 1'b1;
    wait_drained(0);

    // Reset during DATA bit 3: in-flight byte is dropped, next byte goes out
    @(posedge clk);
    #1;
    push(0, 8'h5A, 1'b0);
    push(0, 8'h69, 1'b0);
    wait_pop(0);
    repeat (18) @(posedge clk);
    #1 rrst_n = 1'b0;
    #1;
    check("midframe_reset_tx", 0, tx[0], 1);
    check("midframe_reset_busy", 0, busy[0], 0);
    repeat (2) @(posedge clk);
    #1 rrst_n = 1'b1;
    wait_drained(0);
    check("lost_frames", 0, lost[0], 1);

    // Empty FIFO with enable high: no pops, line stays high
    p = pops[0];
    e = tx_edges[0];
    repeat (100) @(negedge clk);
    check("empty_no_pop", 0, pops[0] - p, 0);
    check("empty_tx_quiet", 0, tx_edges[0] - e, 0);

    for (int k = 0; k < NCH; k++) begin
      check("idle_line", k, idle_bad[k], 0);
      check("scoreboard_empty", k, exp_q[k].size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer for the FIFO's read block (rinc/rempty/rdata) that drains bytes and serialises them as 8-bit asynchronous UART frames.
- Sits entirely in the read clock domain.
- Pops one byte when idle and the FIFO is non-empty, then shifts it out: start bit, 8 data bits LSB first, optional parity, then stop bit(s).

Parameters:
- CLKS_PER_BIT, 16, rclk cycles per serial bit; legal values 2..65535.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 selects even parity, 1 selects odd (ignored when PARITY_EN=0).
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- rclk  input  1  read-domain clock; all state is updated on posedge.
- rrst_n  input  1  asynchronous active-low reset.
- enable  input  1  allows a new byte to be popped; has no effect on a frame already in flight.
- rempty  input  1  FIFO empty flag from the read block.
- rdata  input  8  FIFO read data; combinational, valid at the current raddr.
- rinc  output  1  pop strobe to the read block.
- tx  output  1  serial line; registered; idles high.
- busy  output  1  high from the cycle after the pop through the last stop-bit cycle.
- tx_done  output  1  single-cycle pulse on the last cycle of the final stop bit.

Behaviour:
- Reset (async, rrst_n=0):
  - state=IDLE, tx=1, busy=0, tx_done=0, rinc=0.
  - Bit counter, baud counter and shift register all cleared.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - rinc = enable & ~rempty. This is a Mealy, combinational output, asserted only in IDLE.
  - In the same cycle that rinc=1: capture rdata into the shift register, compute parity, clear the baud counter, go to START.
  - Otherwise stay in IDLE with tx=1.
- Pop rules:
  - At most one rinc pulse per frame.
  - rinc is never asserted while rempty=1.
  - rempty is not sampled again until the frame returns to IDLE, so the one-cycle registered-flag lag in the read block is harmless.
- Bit timing: every serial bit holds tx constant for exactly CLKS_PER_BIT cycles. The baud counter runs 0..CLKS_PER_BIT-1 and the state/bit advances on the terminal count.
- Per-state line value:
  - START: tx=0.
  - DATA: tx=shift[0]. Shift right at each bit end. After bit 7, go to PARITY if PARITY_EN, else STOP.
  - PARITY: tx = (^byte) ^ PARITY_ODD.
  - STOP: tx=1 for STOP_BITS bit periods, then tx_done=1 for that final cycle, then IDLE.
- Latency: tx falls on the first rclk edge after the pop cycle.
- Frame length: (1+8+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
- Back-to-back frames: exactly one IDLE cycle (tx=1) separates consecutive frames when the FIFO stays non-empty and enable=1.
- enable deasserted mid-frame: the current frame completes normally; no further pop occurs.
- rempty rising mid-frame: ignored.
- Reset mid-frame: tx returns high immediately. The popped byte is lost and is not re-read.
- Widths: the baud counter is wide enough to hold CLKS_PER_BIT-1; the bit counter is 3 bits; the stop counter is 1 bit.

Decomposition:
- Shared package (fifo_uart_pkg):
  - FSM state encoding (3-bit localparams or enum).
  - DATA_W=8.
  - Frame-length helper constant.
- One natural sub-module: tx_bit_timer.
  - Parameterised by CLKS_PER_BIT.
  - Inputs: clear, run. Output: single-cycle bit_end pulse.
  - Reused by a future receive block.

Test Plan:
1. Reset with rempty=0 and enable=1: while rrst_n=0, tx=1, rinc=0, busy=0. On release, rinc pulses for exactly one cycle on the first edge.
2. CLKS_PER_BIT=4, PARITY_EN=0, STOP_BITS=1, FIFO holds 0xA5:
   - tx sequence (4 cycles each) = 0, 1,0,1,0,0,1,0,1, 1.
   - Frame is 40 cycles long.
   - tx_done pulses on cycle 40 after the pop.
3. Same settings, FIFO holds 0x3C then 0xC3:
   - Exactly two rinc pulses.
   - Second start bit begins 2 cycles after the first frame's tx_done cycle.
   - Decoded bytes are 0x3C then 0xC3.
4. PARITY_EN=1, byte 0xA5:
   - PARITY_ODD=0 gives parity bit 0; PARITY_ODD=1 gives 1.
   - STOP_BITS=2 gives 8 high stop cycles at CLKS_PER_BIT=4 and a 48-cycle frame.
5. Drop enable in the DATA state of frame 1 with 3 bytes queued: frame 1 completes, no further rinc, and tx stays 1 until enable returns.
6. Assert rrst_n=0 during DATA bit 3 with 2 bytes queued:
   - tx=1 immediately.
   - After release, the next pop transmits the second byte.
   - rempty=1 with enable=1 for 100 cycles produces no rinc and no tx transition.
